// File: rtl/data_sram_resp_pkg.sv
// data_sram_resp_pkg: shared widths, request encodings and helpers for the data-SRAM responder.
package data_sram_resp_pkg;

   localparam int DATA_SRAM_AW = 32;
   localparam int DATA_SRAM_DW = 32;
   localparam int CNT_W = 3;
   localparam int LANES = DATA_SRAM_DW / 8;

   localparam logic [LANES-1:0] MEM_READ = '0;
   localparam logic STOP = 1'b1;
   localparam logic NO_STOP = 1'b0;

   typedef enum logic {IDLE, BUSY} state_e;

   // Any address bit above the word index makes the request out of range.
   function automatic logic addr_in_range(input logic [DATA_SRAM_AW-1:0] addr, input int aw);
      return (addr >> (aw + 2)) == '0;
   endfunction

endpackage

// File: rtl/dsram_array.sv
// dsram_array: word memory with a per-byte-lane write port and a registered read port, no reset.
module dsram_array
   import data_sram_resp_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic                    clk,
   input  logic [LANES-1:0]        we_i,
   input  logic [ADDR_W-1:0]       waddr_i,
   input  logic [DATA_SRAM_DW-1:0] wdata_i,
   input  logic                    re_i,
   input  logic [ADDR_W-1:0]       raddr_i,
   output logic [DATA_SRAM_DW-1:0] rdata_o
);

   logic [DATA_SRAM_DW-1:0] mem_q [2**ADDR_W];
   logic [DATA_SRAM_DW-1:0] rdata_q;

   always_ff @(posedge clk) begin
      for (int i = 0; i < LANES; i++)
         if (we_i[i]) mem_q[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      if (re_i) rdata_q <= mem_q[raddr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_sram_resp.sv
// data_sram_resp: responder for the CPU data-SRAM port with configurable read latency,
// stall request toward the pipeline and an out-of-range error pulse.
module data_sram_resp
   import data_sram_resp_pkg::*;
#(
   parameter int ADDR_W = 10,
   parameter int LAT    = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    data_sram_en,
   input  logic [LANES-1:0]        data_sram_wen,
   input  logic [DATA_SRAM_AW-1:0] data_sram_addr,
   input  logic [DATA_SRAM_DW-1:0] data_sram_wdata,
   output logic [DATA_SRAM_DW-1:0] data_sram_rdata,
   output logic                    rdata_valid,
   output logic                    stallreq_from_mem,
   output logic                    addr_err
);

   if (LAT < 1 || LAT > 8) begin : g_lat_chk
      $error("data_sram_resp: LAT must lie in 1..8");
   end

   state_e                  state;
   logic                    accept, rd_acc, in_rng, fire, fire_oor, arr_re;
   logic [ADDR_W-1:0]       idx, arr_raddr;
   logic [LANES-1:0]        arr_we;
   logic [DATA_SRAM_DW-1:0] arr_rdata;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [ADDR_W-1:0]       idx_q;
   logic                    oor_q, zero_q, valid_q, err_q;

   always_comb begin
      state    = cnt_q == '0 ? IDLE : BUSY;
      accept   = !rst && data_sram_en && state == IDLE;
      in_rng   = addr_in_range(data_sram_addr, ADDR_W);
      rd_acc   = accept && data_sram_wen == MEM_READ;
      idx      = data_sram_addr[ADDR_W+1:2];
      fire     = LAT == 1 ? rd_acc : cnt_q == CNT_W'(1);
      fire_oor = LAT == 1 ? !in_rng : oor_q;
      cnt_d    = rd_acc && LAT > 1 ? CNT_W'(LAT - 1) : state == BUSY ? cnt_q - CNT_W'(1) : cnt_q;
      arr_we   = accept && in_rng ? data_sram_wen : '0;
      arr_re   = fire && !fire_oor;
      arr_raddr = LAT == 1 ? idx : idx_q;
      // Released in the cnt==1 cycle so the load advances exactly as the data lands.
      stallreq_from_mem = !rst && ((rd_acc && LAT > 1) || cnt_q > CNT_W'(1)) ? STOP : NO_STOP;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q   <= '0;
         idx_q   <= '0;
         oor_q   <= 1'b0;
         zero_q  <= 1'b1;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         valid_q <= fire;
         err_q   <= accept && !in_rng;
         if (rd_acc) begin
            idx_q <= idx;
            oor_q <= !in_rng;
         end
         if (fire) zero_q <= fire_oor;
      end
   end

   dsram_array #(.ADDR_W(ADDR_W)) u_array (
      .clk     (clk),
      .we_i    (arr_we),
      .waddr_i (idx),
      .wdata_i (data_sram_wdata),
      .re_i    (arr_re),
      .raddr_i (arr_raddr),
      .rdata_o (arr_rdata)
   );

   // Array output has no reset; zero_q covers both the reset value and out-of-range reads.
   assign data_sram_rdata = zero_q ? '0 : arr_rdata;
   assign rdata_valid     = valid_q;
   assign addr_err        = err_q;

endmodule

// File: doc/data_sram_resp.md
Name: data_sram_resp

Overview:
Responder end of the CPU data-SRAM port (data_sram_en / wen / addr / wdata) driven by the execute stage.
- Holds a byte-writable word memory with a configurable read latency.
- Returns read data plus a one-cycle valid pulse.
- Raises a stall request toward the pipeline stall controller while a multi-cycle read is outstanding.
- Sits at SoC top level in place of the external data RAM, for simulation and FPGA bring-up.

Parameters:
ADDR_W, 10, word-index width; memory depth = 2**ADDR_W 32-bit words.
LAT, 1, read latency in cycles, legal range 1..8; LAT=1 matches plain synchronous SRAM timing.

Ports:
clk  input  1  clock; everything on rising edge.
rst  input  1  reset, asynchronous, active-high.
data_sram_en  input  1  request strobe.
data_sram_wen  input  4  byte write enables; nonzero = write, 0 = read; bit i writes wdata[8i+7:8i].
data_sram_addr  input  32  byte address; word index = addr[ADDR_W+1:2]; addr[1:0] ignored.
data_sram_wdata  input  32  write data, byte-lane aligned by requester.
data_sram_rdata  output  32  read data, registered, holds value until next read completes.
rdata_valid  output  1  one-cycle pulse when data_sram_rdata updates.
stallreq_from_mem  output  1  combinational stall request, OR'd into stall controller.
addr_err  output  1  registered one-cycle pulse on accepted out-of-range request.

Behaviour:
- Reset values: rdata=0, rdata_valid=0, addr_err=0, counter=0, state IDLE. stallreq_from_mem is 0 whenever rst=1. Memory contents are not reset.
- Reset asserted mid-read aborts the read: no rdata_valid, no rdata update. The first cycle after reset release is IDLE.
- State: IDLE (cnt=0) and BUSY (cnt=1..LAT-1).
- Accept condition: en=1 and cnt=0. Requests with cnt!=0 are ignored entirely; the requester is stalled and re-presenting the same request.
- Out of range: addr[31:ADDR_W+2] != 0 means out of range.
  - addr_err pulses in cycle T+1.
  - A write is dropped.
  - A read completes normally with rdata=0.
- Write accepted in cycle T: enabled bytes updated at the edge ending T; no stall, no rdata_valid, rdata unchanged.
- Read accepted in cycle T:
  - cnt loaded with LAT-1.
  - Memory sampled at the edge ending cycle T+LAT-1 from the latched word index.
  - data_sram_rdata valid and rdata_valid=1 in cycle T+LAT.
- Stall: stallreq_from_mem = (read accepted this cycle and LAT>1) or cnt>1.
  - Stall is low in the cycle where cnt=1, so the requesting instruction advances exactly in step with data arrival.
  - Worked example, LAT=3: accept T, stall T and T+1, low T+2, data T+3.
- LAT=1: never stalls; a read accepted in T gives data in T+1. Back-to-back reads every cycle are accepted.
- Read-after-write:
  - A write in T followed by a read of the same word in T+1 returns the new bytes.
  - With LAT>1, a write while BUSY is ignored.
- Partial writes: only enabled lanes change; wen=4'b1111 writes the full word.
- Counter decrements by 1 per cycle while nonzero. It never wraps; 3 bits suffice for LAT<=8.

Decomposition:
- Shared constants file (lib/defines.vh):
  - DATA_SRAM_AW (32) and DATA_SRAM_DW (32).
  - A `MemRead` encoding for wen==0.
- Stall OR in the stall controller uses the existing `Stop/`NoStop macros.
- One sub-module, dsram_array: a 2**ADDR_W x 32 array with a 4-lane byte-write port and a registered read port, no reset.
- data_sram_resp holds the accept logic, latency counter, stall generation, range check and valid pulse.

Test Plan:
- Reset/idle, LAT=1:
  - rst pulse mid-cycle (async) -> rdata=0, rdata_valid=0, stallreq=0 immediately.
  - Write 0xDEADBEEF wen=1111 @0x40, then read @0x40 next cycle -> rdata=0xDEADBEEF with rdata_valid one cycle after the read, no stall.
- Byte lanes:
  - After the above, write wen=0010 wdata=0x0000AA00 @0x40, then read -> 0xDEADAAEF.
  - Write wen=0000 -> treated as read, memory unchanged.
- Latency, LAT=3: read @0x40 in cycle T held while stalled -> stallreq=1 in T and T+1, 0 in T+2; rdata_valid only in T+3; repeated requests in T+1..T+2 produce no extra valid pulse.
- Out of range, ADDR_W=10: write @0x00001000 -> addr_err pulse next cycle, word 0 unchanged. Read @0x00001000 -> addr_err pulse, rdata=0 with rdata_valid.
- Reset mid-read, LAT=4: assert rst in cycle T+2 of a read -> stallreq drops at once; no rdata_valid ever; the next read after release completes in 4 cycles.
- Back-to-back, LAT=1: reads to 0x0, 0x4, 0x8 on consecutive cycles -> three consecutive rdata_valid pulses with matching data.
